btn_cmd_frontend: RTL and testbench



---
 rtl/btn_cmd_frontend_pkg.sv | 28 ++
 rtl/btn_cmd_frontend_if.sv | 14 +
 rtl/btn_debounce_edge.sv | 59 +++++
 rtl/btn_cmd_frontend.sv | 91 +++++++++
 tb/tb_btn_cmd_frontend.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/btn_cmd_frontend_pkg.sv
// Shared types for the button command front end: command codes, pending-FSM
// states and the shift-over-split arbitration rule.
package btn_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_SHIFT = 2'b01,
        CMD_SPLIT = 2'b10
    } cmd_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_PEND  = 2'b01,
        ST_LOCK  = 2'b10
    } state_e;

    // Same-cycle presses resolve to shift, matching the display FSM priority.
    function automatic cmd_e arbitrate(input logic shift_press, input logic split_press);
        cmd_e cmd;
        cmd = CMD_NONE;
        if (shift_press)
            cmd = CMD_SHIFT;
        else if (split_press)
            cmd = CMD_SPLIT;
        return cmd;
    endfunction

endpackage

// File: rtl/btn_cmd_frontend_if.sv
// Button/command bundle between the raw buttons + display FSM and the front end.
// master: the side that owns the buttons and busy; slave: the front end itself.
interface btn_cmd_if;
    logic shift;
    logic split;
    logic busy;
    logic shift_pulse;
    logic split_pulse;

    modport master (output shift, output split, output busy,
                    input  shift_pulse, input split_pulse);
    modport slave  (input  shift, input split, input busy,
                    output shift_pulse, output split_pulse);
endinterface

// File: rtl/btn_debounce_edge.sv
// One button path: 2-FF synchronizer, reversal-restart debounce counter and
// rising-edge press detect on the debounced level.
module btn_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_deb;
    logic          r_deb_d;
    logic [CW-1:0] r_cnt;

    // Two-stage synchronizer for the asynchronous raw level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= btn;
            r_sync <= r_meta;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples;
    // any agreement restarts the count, and the count tops out at CNT_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_deb <= r_sync;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delayed debounced level for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_deb_d <= 1'b0;
        else
            r_deb_d <= r_deb;
    end

    assign level = r_deb;
    assign press = r_deb & ~r_deb_d;

endmodule

// File: rtl/btn_cmd_frontend.sv
// Button front end: debounces shift/split, arbitrates same-cycle presses and
// holds one pending command until the display FSM is idle, then emits a
// one-cycle registered pulse.
module btn_cmd_frontend
    import btn_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic     clk,
    input  logic     rst,
    btn_cmd_if.slave bus
);
    logic       w_shift_press;
    logic       w_split_press;
    logic       w_shift_level;
    logic       w_split_level;
    logic [1:0] w_unused_levels;
    cmd_e       w_event;

    state_e r_state;
    cmd_e   r_pend;
    logic   r_shift_pulse;
    logic   r_split_pulse;

    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.shift),
        .level (w_shift_level),
        .press (w_shift_press)
    );

    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_split (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.split),
        .level (w_split_level),
        .press (w_split_press)
    );

    // Debounced levels are not needed here; only the press events drive commands.
    assign w_unused_levels = {w_shift_level, w_split_level};

    assign w_event = arbitrate(w_shift_press, w_split_press);

    // Pending-command FSM: first command wins while waiting on busy; LOCK gives
    // the downstream busy one cycle to rise before anything else can issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_EMPTY;
            r_pend        <= CMD_NONE;
            r_shift_pulse <= 1'b0;
            r_split_pulse <= 1'b0;
        end else begin
            r_shift_pulse <= 1'b0;
            r_split_pulse <= 1'b0;
            case (r_state)
                ST_EMPTY: begin
                    if (w_event != CMD_NONE) begin
                        r_pend  <= w_event;
                        r_state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!bus.busy) begin
                        r_shift_pulse <= (r_pend == CMD_SHIFT);
                        r_split_pulse <= (r_pend == CMD_SPLIT);
                        r_pend        <= CMD_NONE;
                        r_state       <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_event != CMD_NONE) begin
                        r_pend  <= w_event;
                        r_state <= ST_PEND;
                    end else begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: begin
                    r_pend  <= CMD_NONE;
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign bus.shift_pulse = r_shift_pulse;
    assign bus.split_pulse = r_split_pulse;

endmodule

// File: tb/tb_btn_cmd_frontend.sv
// Bench for btn_cmd_frontend with DEBOUNCE_CYCLES=4: directed scenarios plus a
// random phase, every cycle compared against a behavioural reference model.
module tb_btn_cmd_frontend;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    btn_cmd_if bus ();

    btn_cmd_frontend #(.DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model. Button index 0 = shift, 1 = split.
    // A level is accepted once the synchronized input has shown the other
    // value on D consecutive edges (tracked as a run length of equal samples).
    bit m_ff1[2];
    bit m_sync[2];
    bit m_last[2];
    int m_run[2];
    bit m_deb[2];
    bit m_deb_d[2];
    int m_pend;          // 0 none, 1 shift, 2 split
    bit m_lock;
    bit m_sp;
    bit m_pp;

    // Observation bookkeeping
    int cyc = 0;
    int n_sh, n_sp, t_sh, t_sp, t_sh_first;
    bit prev_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_ff1[b] = 0; m_sync[b] = 0; m_last[b] = 0; m_run[b] = 0;
            m_deb[b] = 0; m_deb_d[b] = 0;
        end
        m_pend = 0; m_lock = 0; m_sp = 0; m_pp = 0;
        prev_pulse = 0;
    endtask

    task automatic model_edge(input bit raw_sh, input bit raw_sp, input bit busy);
        bit ev_sh, ev_sp;
        int ev;
        bit raw[2];
        raw[0] = raw_sh; raw[1] = raw_sp;
        ev_sh = m_deb[0] && !m_deb_d[0];
        ev_sp = m_deb[1] && !m_deb_d[1];
        ev = ev_sh ? 1 : (ev_sp ? 2 : 0);
        m_sp = 0; m_pp = 0;
        if (m_lock) begin
            m_lock = 0;
            m_pend = ev;
        end else if (m_pend != 0) begin
            if (!busy) begin
                m_sp = (m_pend == 1);
                m_pp = (m_pend == 2);
                m_pend = 0;
                m_lock = 1;
            end
        end else begin
            m_pend = ev;
        end
        for (int b = 0; b < 2; b++) begin
            m_deb_d[b] = m_deb[b];
            m_run[b] = (m_sync[b] == m_last[b]) ? m_run[b] + 1 : 1;
            m_last[b] = m_sync[b];
            if (m_sync[b] != m_deb[b] && m_run[b] >= D) m_deb[b] = m_sync[b];
            m_sync[b] = m_ff1[b];
            m_ff1[b] = raw[b];
        end
    endtask

    task automatic tick();
        bit any;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(bus.shift, bus.split, bus.busy);
        #1;
        cyc++;
        chk("shift_pulse", bus.shift_pulse, m_sp);
        chk("split_pulse", bus.split_pulse, m_pp);
        chk("pulse_exclusive", bus.shift_pulse & bus.split_pulse, 0);
        any = bus.shift_pulse | bus.split_pulse;
        chk("pulse_back_to_back", any & prev_pulse, 0);
        prev_pulse = any;
        if (bus.shift_pulse === 1'b1) begin
            n_sh++; t_sh = cyc;
            if (n_sh == 1) t_sh_first = cyc;
        end
        if (bus.split_pulse === 1'b1) begin
            n_sp++; t_sp = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        n_sh = 0; n_sp = 0; t_sh = -1; t_sp = -1; t_sh_first = -1;
    endtask

    int base;
    int hi_runs[3] = '{3, 2, 3};

    initial begin
        bus.shift = 0; bus.split = 0; bus.busy = 0;
        model_reset();
        clr();

        // Reset state
        #2;
        chk("reset_shift_pulse", bus.shift_pulse, 0);
        chk("reset_split_pulse", bus.split_pulse, 0);
        ticks(3);
        rst = 0;
        ticks(5);

        // Clean press held for 100 cycles: one pulse at edge 8
        clr(); bus.shift = 1; base = cyc;
        ticks(100);
        chk("clean_n_shift", n_sh, 1);
        chk("clean_t_shift", t_sh - base, 8);
        chk("clean_n_split", n_sp, 0);
        bus.shift = 0; ticks(20);

        // Bounce: high runs 3,2,3 separated by 2-cycle lows, then held
        clr();
        for (int k = 0; k < 3; k++) begin
            bus.split = 1; ticks(hi_runs[k]);
            bus.split = 0; ticks(2);
        end
        bus.split = 1; base = cyc;
        ticks(40);
        chk("bounce_n_split", n_sp, 1);
        chk("bounce_t_split", t_sp - base, 8);
        chk("bounce_n_shift", n_sh, 0);
        // Bouncy release
        clr();
        bus.split = 0; ticks(2); bus.split = 1; ticks(1);
        bus.split = 0; ticks(3); bus.split = 1; ticks(2);
        bus.split = 0; ticks(40);
        chk("release_n_split", n_sp, 0);

        // Simultaneous press: shift wins
        clr(); bus.shift = 1; bus.split = 1;
        ticks(30);
        chk("simul_n_shift", n_sh, 1);
        chk("simul_n_split", n_sp, 0);
        bus.shift = 0; bus.split = 0; ticks(20);

        // Busy hold: split pending, later shift dropped, issue at edge 61
        clr(); bus.busy = 1; bus.split = 1; base = cyc;
        ticks(20); bus.shift = 1;
        ticks(40); bus.busy = 0;
        ticks(30);
        chk("busy_t_split", t_sp - base, 61);
        chk("busy_n_split", n_sp, 1);
        chk("busy_n_shift", n_sh, 0);
        bus.shift = 0; bus.split = 0; ticks(20);

        // Lock window: second shift press event lands in the LOCK cycle
        clr(); bus.busy = 1; bus.shift = 1; base = cyc;
        ticks(10); bus.shift = 0;
        ticks(10); bus.shift = 1;
        ticks(5);  bus.busy = 0;
        ticks(25);
        chk("lock_n_shift", n_sh, 2);
        chk("lock_t_first", t_sh_first - base, 26);
        chk("lock_gap", t_sh - t_sh_first, 2);
        bus.shift = 0; ticks(20);

        // Async reset while pending with busy high, shift held throughout
        clr(); bus.busy = 1; bus.shift = 1;
        ticks(12);
        #2 rst = 1; model_reset();
        #1;
        chk("rst_pend_shift_pulse", bus.shift_pulse, 0);
        chk("rst_pend_split_pulse", bus.split_pulse, 0);
        ticks(3);
        rst = 0; bus.busy = 0; clr(); base = cyc;
        ticks(8);
        chk("rst_recover_n_shift", n_sh, 1);
        chk("rst_recover_t_shift", t_sh - base, 8);
        // Reset landing inside a pulse cycle drops it at once
        #2 rst = 1; model_reset();
        #1;
        chk("rst_mid_pulse", bus.shift_pulse, 0);
        ticks(2);
        rst = 0;
        ticks(20);
        bus.shift = 0; ticks(20);

        // Random phase against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0)  bus.shift = ~bus.shift;
            if ($urandom_range(0, 6) == 0)  bus.split = ~bus.split;
            if ($urandom_range(0, 15) == 0) bus.busy  = ~bus.busy;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
